clk_period_meter: RTL and testbench

- Measures an asynchronous, slow, clock-like input (`sigIn`) in units of the system clock `clkIn`.
- Reports the period and high time of every completed `sigIn` cycle.
- Counterpart of the team's clock-division logic: it verifies and characterises divided or external clocks.
- Used in self-test and frequency monitoring.

---
 rtl/clk_period_meter.sv | 142 ++++++++++++++
 tb/tb_clk_period_meter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period and high-time meter for a slow asynchronous clock-like input
//
// Purpose: measures sigIn in units of clkIn. After the first synchronized
// rising edge, every further rising edge reports the clkIn count between the
// last two edges (period) and how many of those cycles sigIn was high
// (highTime), together with a one-cycle valid pulse. If no edge arrives
// within MAX_PERIOD cycles the meter raises timeout until the next edge,
// which restarts measurement without a report.
//
// Ports:
//   clkIn    - system clock, all state on its rising edge
//   reset    - synchronous, active-high reset
//   sigIn    - asynchronous input being measured
//   period   - clkIn cycles between the last two sigIn rising edges
//   highTime - clkIn cycles sigIn was high within that period
//   valid    - one-cycle pulse when period/highTime update
//   timeout  - high while no rising edge has been seen for MAX_PERIOD cycles

module clk_period_meter #(
    parameter int WIDTH      = 32,
    parameter int MAX_PERIOD = 1000000
) (
    input  logic             clkIn,
    input  logic             reset,
    input  logic             sigIn,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] highTime,
    output logic             valid,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_PERIOD);
    localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(MAX_PERIOD - 1);

    typedef enum logic [1:0] {
        ARM  = 2'd0,
        MEAS = 2'd1,
        TOUT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic sig_meta;
    logic sig_sync;
    logic sig_prev;
    logic rise;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hcnt;

    logic restart;
    logic report;
    logic advance;

    // Two-flop synchronizer plus one delay flop for edge detection.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            sig_meta <= 1'b0;
            sig_sync <= 1'b0;
            sig_prev <= 1'b0;
        end else begin
            sig_meta <= sigIn;
            sig_sync <= sig_meta;
            sig_prev <= sig_sync;
        end
    end

    assign rise = sig_sync & ~sig_prev;

    always_ff @(posedge clkIn) begin
        if (reset) begin
            state <= ARM;
        end else begin
            state <= state_next;
        end
    end

    // A rise on the last countable cycle wins over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            ARM:     if (rise) state_next = MEAS;
            MEAS:    if (!rise && (cnt == LAST_CNT)) state_next = TOUT;
            TOUT:    if (rise) state_next = MEAS;
            default: state_next = ARM;
        endcase
    end

    // Only an edge that closes a period counted from a previous edge reports;
    // edges seen in ARM or TOUT just restart the counters.
    always_comb begin
        restart = 1'b0;
        report  = 1'b0;
        advance = 1'b0;
        case (state)
            ARM:  restart = rise;
            MEAS: begin
                if (rise) begin
                    restart = 1'b1;
                    report  = 1'b1;
                end else if (cnt != LAST_CNT) begin
                    advance = 1'b1;
                end
            end
            TOUT: restart = rise;
            default: begin
                restart = 1'b0;
            end
        endcase
    end

    // hcnt restarts at 1 because the rise cycle itself has sigSync high.
    always_ff @(posedge clkIn) begin
        if (reset) begin
            cnt      <= '0;
            hcnt     <= '0;
            period   <= '0;
            highTime <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            valid   <= report;
            timeout <= (state_next == TOUT);
            if (report) begin
                period   <= cnt + ONE;
                highTime <= hcnt;
            end
            if (restart) begin
                cnt  <= '0;
                hcnt <= ONE;
            end else if (advance) begin
                cnt <= cnt + ONE;
                if (sig_sync && (hcnt != MAX_W)) begin
                    hcnt <= hcnt + ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - self-checking bench for clk_period_meter
//
// Two instances share sigIn/reset: dut_a with a large MAX_PERIOD for normal
// measurements and dut_b with MAX_PERIOD=50 for the timeout boundaries.
// The reference model works from the recorded sigIn history: a rising edge
// of sigIn sampled at clkIn edge n is acted on at edge n+2, the period is the
// difference of edge indices and the high time is a sum over the history.

module tb_clk_period_meter;

    localparam int MAX_A = 1000;
    localparam int MAX_B = 50;
    localparam int WA    = 32;
    localparam int WB    = 8;
    localparam int HN    = 4096;

    typedef struct {
        int p;
        int h;
    } meas_t;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    logic sig_in = 1'b0;

    logic [WA-1:0] period_a;
    logic [WA-1:0] high_a;
    logic          valid_a;
    logic          timeout_a;
    logic [WB-1:0] period_b;
    logic [WB-1:0] high_b;
    logic          valid_b;
    logic          timeout_b;

    always #5 clk = ~clk;

    clk_period_meter #(.WIDTH(WA), .MAX_PERIOD(MAX_A)) dut_a (
        .clkIn(clk), .reset(reset), .sigIn(sig_in),
        .period(period_a), .highTime(high_a), .valid(valid_a), .timeout(timeout_a)
    );

    clk_period_meter #(.WIDTH(WB), .MAX_PERIOD(MAX_B)) dut_b (
        .clkIn(clk), .reset(reset), .sigIn(sig_in),
        .period(period_b), .highTime(high_b), .valid(valid_b), .timeout(timeout_b)
    );

    // Input history, one entry per clkIn edge.
    bit h  [HN];
    bit rh [HN];
    int cyc = 0;

    always @(posedge clk) begin
        if (cyc < HN) begin
            h[cyc]  <= sig_in;
            rh[cyc] <= reset;
        end
        cyc <= cyc + 1;
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Model state
    bit started   = 1'b0;
    int floor_idx = 0;
    int m_period [2];
    int m_high   [2];
    bit m_valid  [2];
    bit m_tout   [2];
    bit m_armed  [2];
    int m_last   [2];

    // History before the last reset edge is invisible to the synchronizer.
    function automatic bit hv(input int j);
        if (j < 0 || j < floor_idx || j >= HN) return 1'b0;
        return h[j];
    endfunction

    task automatic step_model(input int k);
        bit rise;
        int n;
        int mx;
        if (rh[k]) begin
            started   = 1'b1;
            floor_idx = k + 1;
            for (int i = 0; i < 2; i++) begin
                m_period[i] = 0;
                m_high[i]   = 0;
                m_valid[i]  = 1'b0;
                m_tout[i]   = 1'b0;
                m_armed[i]  = 1'b0;
                m_last[i]   = 0;
            end
            return;
        end
        rise = (k >= 2) && hv(k - 2) && !hv(k - 3);
        for (int i = 0; i < 2; i++) begin
            mx = (i == 0) ? MAX_A : MAX_B;
            m_valid[i] = 1'b0;
            if (rise) begin
                n = k - 2;
                if (m_armed[i] && !m_tout[i]) begin
                    m_valid[i]  = 1'b1;
                    m_period[i] = n - m_last[i];
                    m_high[i]   = 0;
                    for (int j = m_last[i]; j < n; j++) m_high[i] += int'(hv(j));
                end
                m_armed[i] = 1'b1;
                m_tout[i]  = 1'b0;
                m_last[i]  = n;
            end else if (m_armed[i] && !m_tout[i] && (k - m_last[i] - 2) == mx) begin
                m_tout[i] = 1'b1;
            end
        end
    endtask

    meas_t qa[$];
    meas_t qb[$];
    int    tout_rise_b = -1;
    bit    tout_seen_b = 1'b0;
    bit    prev_tout_b = 1'b0;

    // Per-cycle compare against the model, sampled on the falling edge.
    initial begin
        int k;
        forever begin
            @(negedge clk);
            k = cyc - 1;
            if (k >= 0 && k < HN) begin
                step_model(k);
                if (started) begin
                    check("valid_a",   valid_a,   m_valid[0]);
                    check("timeout_a", timeout_a, m_tout[0]);
                    check("period_a",  period_a,  m_period[0]);
                    check("high_a",    high_a,    m_high[0]);
                    check("valid_b",   valid_b,   m_valid[1]);
                    check("timeout_b", timeout_b, m_tout[1]);
                    check("period_b",  period_b,  m_period[1]);
                    check("high_b",    high_b,    m_high[1]);
                    if (valid_a === 1'b1) qa.push_back('{int'(period_a), int'(high_a)});
                    if (valid_b === 1'b1) qb.push_back('{int'(period_b), int'(high_b)});
                    if (timeout_b === 1'b1) tout_seen_b = 1'b1;
                    if (timeout_b === 1'b1 && !prev_tout_b) tout_rise_b = k;
                    prev_tout_b = (timeout_b === 1'b1);
                end
            end
        end
    end

    task automatic hold(input bit v, input int n);
        sig_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int e8;
        int ep;
        int eh;

        // Reset held three cycles while sigIn toggles.
        reset = 1'b1;
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        check("rst_period_a",  period_a,  0);
        check("rst_high_a",    high_a,    0);
        check("rst_valid_a",   valid_a,   0);
        check("rst_timeout_a", timeout_a, 0);
        check("rst_period_b",  period_b,  0);
        reset = 1'b0;
        hold(1'b0, 5);

        // 101-cycle period, 51 high: the arming edge reports nothing.
        qa.delete();
        qb.delete();
        repeat (6) begin
            hold(1'b1, 51);
            hold(1'b0, 50);
        end
        check("p101_count_a", qa.size(), 5);
        for (int i = 0; i < qa.size(); i++) begin
            check("p101_period_a", qa[i].p, 101);
            check("p101_high_a",   qa[i].h, 51);
        end
        check("p101_count_b", qb.size(), 0);
        check("p101_model_period", m_period[0], 101);
        check("p101_model_high",   m_high[0],   51);

        // Period 10/5 switched to 7/3.
        qa.delete();
        qb.delete();
        repeat (4) begin
            hold(1'b1, 5);
            hold(1'b0, 5);
        end
        repeat (4) begin
            hold(1'b1, 3);
            hold(1'b0, 4);
        end
        e8 = cyc;
        hold(1'b1, 3);
        hold(1'b0, 4);
        check("sw_count_a", qa.size(), 9);
        for (int i = 0; i < qa.size(); i++) begin
            ep = (i == 0) ? 101 : (i < 5) ? 10 : 7;
            eh = (i == 0) ? 51  : (i < 5) ? 5  : 3;
            check("sw_period_a", qa[i].p, ep);
            check("sw_high_a",   qa[i].h, eh);
        end
        check("sw_count_b", qb.size(), 8);
        for (int i = 0; i < qb.size(); i++) begin
            check("sw_period_b", qb[i].p, (i < 4) ? 10 : 7);
            check("sw_high_b",   qb[i].h, (i < 4) ? 5 : 3);
        end

        // Stuck low: dut_b times out 50 cycles after the last rise.
        qa.delete();
        qb.delete();
        tout_rise_b = -1;
        hold(1'b0, 60);
        check("stuck_timeout_b", timeout_b, 1);
        check("stuck_timeout_a", timeout_a, 0);
        check("stuck_tout_cycle_b", tout_rise_b, e8 + 2 + MAX_B);
        check("stuck_count_b", qb.size(), 0);
        hold(1'b1, 10);
        hold(1'b0, 10);
        hold(1'b1, 10);
        hold(1'b0, 10);
        check("recover_timeout_b", timeout_b, 0);
        check("recover_count_b", qb.size(), 1);
        if (qb.size() > 0) begin
            check("recover_period_b", qb[0].p, 20);
            check("recover_high_b",   qb[0].h, 10);
        end
        check("recover_count_a", qa.size(), 2);
        if (qa.size() == 2) begin
            check("recover_period_a0", qa[0].p, 67);
            check("recover_high_a0",   qa[0].h, 3);
            check("recover_period_a1", qa[1].p, 20);
        end

        // Edges exactly MAX_PERIOD apart on dut_b.
        qa.delete();
        qb.delete();
        tout_seen_b = 1'b0;
        hold(1'b1, 25);
        hold(1'b0, 25);
        hold(1'b1, 25);
        hold(1'b0, 25);
        hold(1'b1, 25);
        hold(1'b0, 10);
        check("max_count_b", qb.size(), 3);
        for (int i = 0; i < qb.size(); i++) begin
            check("max_period_b", qb[i].p, (i == 0) ? 20 : 50);
            check("max_high_b",   qb[i].h, (i == 0) ? 10 : 25);
        end
        check("max_tout_seen_b", tout_seen_b, 0);
        check("max_model_period_b", m_period[1], 50);

        // Reset 30 cycles into a 101-cycle period; sigIn is still high at
        // release, so the cleared synchronizer sees a fresh edge there.
        qa.delete();
        qb.delete();
        hold(1'b1, 30);
        check("mid_pre_count_a", qa.size(), 1);
        reset = 1'b1;
        hold(1'b1, 2);
        check("mid_rst_period_a", period_a, 0);
        check("mid_rst_valid_a",  valid_a,  0);
        check("mid_rst_tout_b",   timeout_b, 0);
        reset = 1'b0;
        qa.delete();
        qb.delete();
        hold(1'b1, 19);
        hold(1'b0, 50);
        hold(1'b1, 51);
        hold(1'b0, 50);
        hold(1'b1, 51);
        hold(1'b0, 10);
        check("mid_count_a", qa.size(), 2);
        if (qa.size() == 2) begin
            check("mid_period_a0", qa[0].p, 69);
            check("mid_high_a0",   qa[0].h, 19);
            check("mid_period_a1", qa[1].p, 101);
            check("mid_high_a1",   qa[1].h, 51);
        end
        check("mid_count_b", qb.size(), 0);

        hold(1'b0, 5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
